// File: rtl/dmem_port_arbiter.sv
// Arbitrates the fetch and load/store ports onto a single-port data memory (IDLE/ACCESS/RESP).
// Optional build macro MISALIGN_TRAP_EN: misaligned halfword/word ls requests fault without touching memory.
module dmem_port_arbiter #(
  parameter int FAIR = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [1:0]  ls_width,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_gnt,
  output logic        ls_rvalid,
  output logic [31:0] ls_rdata,
  output logic        ls_fault,
  output logic        mem_en,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_nxt;
  logic        any_req, grant_ls, trap;
  logic        owner_ls, last_ls, gnt_q, fault_q, we_q;
  logic [1:0]  width_q;
  logic [31:0] addr_q, wdata_q, if_rdata_q, ls_rdata_q;
  logic [3:0]  base;
  logic [6:0]  we_wide;

  // owner_ls/last_ls: 1 = load/store port, 0 = fetch port
  always_comb begin
    any_req  = if_req | ls_req;
    grant_ls = ls_req;
    if (if_req && ls_req) grant_ls = (FAIR != 0) ? !last_ls : 1'b1;
  end

`ifdef MISALIGN_TRAP_EN
  assign trap = grant_ls && ((ls_width == 2'b01 && ls_addr[0]) ||
                             (ls_width == 2'b10 && ls_addr[1:0] != 2'b00));
`else
  assign trap = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    mem_en    = 1'b0;
    mem_we    = 4'b0000;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    if_rvalid = 1'b0;
    ls_rvalid = 1'b0;
    base      = 4'b0000;
    we_wide   = 7'd0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (any_req) state_nxt = trap ? RESP : ACCESS;
      end
      ACCESS: begin
        mem_en   = 1'b1;
        mem_addr = {addr_q[31:2], 2'b00};
        case (width_q)
          2'b00:   base = 4'b0001;
          2'b01:   base = 4'b0011;
          2'b10:   base = 4'b1111;
          default: base = 4'b0000;
        endcase
        we_wide   = {3'b000, base} << addr_q[1:0];
        mem_we    = we_q ? we_wide[3:0] : 4'b0000;
        mem_wdata = wdata_q << {addr_q[1:0], 3'b000};
        if (mem_ready) state_nxt = RESP;
      end
      RESP: begin
        if_rvalid = !owner_ls;
        ls_rvalid = owner_ls;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_ls    <= 1'b0;
      owner_ls   <= 1'b0;
      gnt_q      <= 1'b0;
      fault_q    <= 1'b0;
      we_q       <= 1'b0;
      width_q    <= 2'b00;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      if_rdata_q <= 32'd0;
      ls_rdata_q <= 32'd0;
    end else begin
      gnt_q <= 1'b0;
      if (state == IDLE && any_req) begin
        gnt_q    <= 1'b1;
        owner_ls <= grant_ls;
        last_ls  <= grant_ls;
        fault_q  <= trap;
        we_q     <= grant_ls & ls_we;
        width_q  <= grant_ls ? ls_width : 2'b10;
        addr_q   <= grant_ls ? ls_addr : if_addr;
        wdata_q  <= grant_ls ? ls_wdata : 32'd0;
        if (trap) ls_rdata_q <= 32'd0;
      end
      // stores complete with a zero word so ls_rdata never shows stale read data
      if (state == ACCESS && mem_ready) begin
        if (owner_ls) ls_rdata_q <= we_q ? 32'd0 : mem_rdata;
        else          if_rdata_q <= mem_rdata;
      end
    end
  end

  assign if_gnt   = gnt_q & !owner_ls;
  assign ls_gnt   = gnt_q & owner_ls;
  assign if_rdata = if_rdata_q;
  assign ls_rdata = ls_rdata_q;
  assign ls_fault = ls_rvalid & fault_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: random traffic against a lane-level reference model,
// plus directed fetch/store/wait/reset/misalign/tie cases and a FAIR=0 starvation instance.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0, mem_ready = 1'b0;
  logic [31:0] if_addr = 32'd0, ls_addr = 32'd0, ls_wdata = 32'd0, mem_rdata;
  logic [1:0]  ls_width = 2'b00;
  logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, ls_fault, mem_en, busy;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_we;

  logic        p0_rst = 1'b1;
  logic        p0_if_gnt, p0_if_rvalid, p0_ls_gnt, p0_ls_rvalid, p0_ls_fault, p0_mem_en, p0_busy;
  logic [31:0] p0_if_rdata, p0_ls_rdata, p0_mem_addr, p0_mem_wdata;
  logic [3:0]  p0_mem_we;

  always #5 clk = ~clk;

  function automatic logic [31:0] rmem(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  assign mem_rdata = rmem(mem_addr);

  dmem_port_arbiter #(.FAIR(1)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_width(ls_width), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_fault(ls_fault),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
  );

  dmem_port_arbiter #(.FAIR(0)) u_dut_p0 (
    .clk(clk), .rst(p0_rst),
    .if_req(1'b1), .if_addr(32'h0000_0020), .if_gnt(p0_if_gnt), .if_rvalid(p0_if_rvalid), .if_rdata(p0_if_rdata),
    .ls_req(1'b1), .ls_we(1'b0), .ls_width(2'b10), .ls_addr(32'h0000_0010), .ls_wdata(32'd0),
    .ls_gnt(p0_ls_gnt), .ls_rvalid(p0_ls_rvalid), .ls_rdata(p0_ls_rdata), .ls_fault(p0_ls_fault),
    .mem_en(p0_mem_en), .mem_we(p0_mem_we), .mem_addr(p0_mem_addr), .mem_wdata(p0_mem_wdata),
    .mem_rdata(32'd0), .mem_ready(1'b1), .busy(p0_busy)
  );

  typedef struct {
    bit          is_ls;
    bit          fault;
    bit          chk_wdata;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  we;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_chk = 0, n_pass = 0;
  logic [31:0] hold_if = 32'd0, hold_ls = 32'd0;
  bit          last_ls_m = 1'b0;
  int          ready_mode = 0;
  int          acc_k = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail1(input string name);
    n_chk++;
    $display("FAIL %s: event not expected or did not occur", name);
  endtask

  // Reference: byte lanes touched are [off, off+size) clipped to the word; data bytes slide up by off.
  function automatic exp_t model(input bit is_ls, input bit we, input logic [1:0] width,
                                 input logic [31:0] addr, input logic [31:0] wdata);
    exp_t e;
    int off, size;
    off         = int'(addr[1:0]);
    size        = (width == 2'b00) ? 1 : (width == 2'b01) ? 2 : (width == 2'b10) ? 4 : 0;
    e.is_ls     = is_ls;
    e.chk_wdata = is_ls;
    e.fault     = 1'b0;
    e.addr      = addr & 32'hFFFF_FFFC;
    e.we        = 4'b0000;
    e.wdata     = 32'd0;
    for (int i = 0; i < 4; i++) begin
      if (we && i >= off && i < off + size) e.we[i] = 1'b1;
      if (i >= off) e.wdata[8*i +: 8] = wdata[8*(i-off) +: 8];
    end
    e.rdata = we ? 32'd0 : rmem(e.addr);
`ifdef MISALIGN_TRAP_EN
    if (is_ls && ((width == 2'b01 && off[0]) || (width == 2'b10 && off != 0))) begin
      e.fault = 1'b1;
      e.rdata = 32'd0;
    end
`endif
    return e;
  endfunction

  always begin
    @(posedge clk); #1;
    if (mem_en) acc_k++; else acc_k = 0;
    case (ready_mode)
      0:       mem_ready = ($urandom_range(0, 2) == 0);
      1:       mem_ready = 1'b0;
      2:       mem_ready = 1'b1;
      default: mem_ready = (acc_k == 6);
    endcase
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (if_gnt || ls_gnt) begin
        if (exp_q.size() == 0) fail1("gnt_unexpected");
        else begin
          chk("gnt_port", 32'(ls_gnt), 32'(exp_q[0].is_ls));
          chk("gnt_single", 32'(if_gnt & ls_gnt), 32'd0);
        end
      end
      if (mem_en) begin
        if (exp_q.size() == 0) fail1("mem_en_unexpected");
        else begin
          chk("mem_en_on_trap", 32'(exp_q[0].fault), 32'd0);
          chk("mem_addr", mem_addr, exp_q[0].addr);
          chk("mem_we", 32'(mem_we), 32'(exp_q[0].we));
          if (exp_q[0].chk_wdata) chk("mem_wdata", mem_wdata, exp_q[0].wdata);
          chk("busy_access", 32'(busy), 32'd1);
        end
      end
      if (if_rvalid || ls_rvalid) begin
        if (exp_q.size() == 0) fail1("rvalid_unexpected");
        else begin
          mon_e = exp_q.pop_front();
          chk("rvalid_port", 32'(ls_rvalid), 32'(mon_e.is_ls));
          chk("rvalid_single", 32'(if_rvalid & ls_rvalid), 32'd0);
          chk("ls_fault", 32'(ls_fault), 32'(mon_e.is_ls & mon_e.fault));
          chk("busy_resp", 32'(busy), 32'd1);
          if (mon_e.is_ls) hold_ls = mon_e.rdata;
          else             hold_if = mon_e.rdata;
        end
      end
      chk("if_rdata", if_rdata, hold_if);
      chk("ls_rdata", ls_rdata, hold_ls);
    end
  end

  // Call with the DUT in IDLE, just after a clock edge. Returns grant/rvalid cycle and ACCESS length.
  task automatic issue(input bit add_if, input bit add_ls, input logic [31:0] ia,
                       input bit we, input logic [1:0] w, input logic [31:0] la, input logic [31:0] ld,
                       output bit gport, output int gn, output int rn, output int an);
    bit win_ls;
    if (add_if && !if_req) begin if_req = 1'b1; if_addr = ia; end
    if (add_ls && !ls_req) begin
      ls_req = 1'b1; ls_we = we; ls_width = w; ls_addr = la; ls_wdata = ld;
    end
    win_ls    = (if_req && ls_req) ? !last_ls_m : ls_req;
    last_ls_m = win_ls;
    exp_q.push_back(win_ls ? model(1'b1, ls_we, ls_width, ls_addr, ls_wdata)
                           : model(1'b0, 1'b0, 2'b10, if_addr, 32'd0));
    gport = 1'b0; gn = 0; rn = 0; an = 0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (mem_en) an++;
      if (if_gnt || ls_gnt) begin gn = n; gport = ls_gnt; end
      if (if_gnt) begin if_req = 1'b0; if_addr = $urandom; end
      if (ls_gnt) begin
        ls_req = 1'b0; ls_addr = $urandom; ls_wdata = $urandom;
        ls_we = 1'($urandom); ls_width = 2'($urandom);
      end
      if (if_rvalid || ls_rvalid) begin rn = n; break; end
    end
    if (rn == 0) fail1("txn_timeout");
    @(posedge clk); #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    bit gp;
    int gn, rn, an, cnt, c_if, c_ls;
    bit a_if, a_ls;

    ready_mode = 2;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_bus", mem_addr | mem_wdata | 32'(mem_we), 32'd0);
    chk("rst_gnt_rvalid", 32'({if_gnt, ls_gnt, if_rvalid, ls_rvalid, ls_fault}), 32'd0);
    chk("rst_rdata", if_rdata | ls_rdata, 32'd0);
    rst = 1'b0;

    // fetch at 0x100, memory ready immediately
    issue(1'b1, 1'b0, 32'h0000_0100, 1'b0, 2'b00, 32'd0, 32'd0, gp, gn, rn, an);
    chk("fetch_gnt_cycle", 32'(gn), 32'd1);
    chk("fetch_rvalid_cycle", 32'(rn), 32'd2);
    chk("fetch_access_len", 32'(an), 32'd1);

    // byte store to 0x203
    issue(1'b0, 1'b1, 32'd0, 1'b1, 2'b00, 32'h0000_0203, 32'h0000_00AB, gp, gn, rn, an);
    chk("store_gnt_port", 32'(gp), 32'd1);

    // memory stalls for five ACCESS cycles
    ready_mode = 3;
    issue(1'b0, 1'b1, 32'd0, 1'b0, 2'b10, 32'h0000_0510, 32'h1234_5678, gp, gn, rn, an);
    chk("wait_access_len", 32'(an), 32'd6);
    chk("wait_rvalid_cycle", 32'(rn), 32'd7);

    // misaligned word load at 0x302
    ready_mode = 2;
    issue(1'b0, 1'b1, 32'd0, 1'b0, 2'b10, 32'h0000_0302, 32'd0, gp, gn, rn, an);
`ifdef MISALIGN_TRAP_EN
    chk("misalign_access_len", 32'(an), 32'd0);
    chk("misalign_rvalid_cycle", 32'(rn), 32'd1);
`else
    chk("misalign_access_len", 32'(an), 32'd1);
    chk("misalign_rvalid_cycle", 32'(rn), 32'd2);
`endif

    // reset while stuck in ACCESS
    ready_mode = 1;
    if_req = 1'b1; if_addr = 32'h0000_0440;
    exp_q.push_back(model(1'b0, 1'b0, 2'b10, 32'h0000_0440, 32'd0));
    last_ls_m = 1'b0;
    cnt = 0;
    while (!if_gnt && cnt < 20) begin @(posedge clk); #1; cnt++; end
    if (!if_gnt) fail1("rst_test_gnt_timeout");
    if_req = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    hold_if = 32'd0; hold_ls = 32'd0; last_ls_m = 1'b0;
    chk("midrst_mem_en", 32'(mem_en), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    cnt = 0;
    repeat (5) begin @(posedge clk); #1; if (if_rvalid || ls_rvalid) cnt++; end
    chk("midrst_no_rvalid", 32'(cnt), 32'd0);
    ready_mode = 0;
    issue(1'b1, 1'b0, 32'h0000_0444, 1'b0, 2'b00, 32'd0, 32'd0, gp, gn, rn, an);
    chk("post_rst_complete", 32'(rn != 0), 32'd1);

    // continuous tie: last grant was fetch, so LS, IF, LS, IF
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 1'b1, $urandom, 1'($urandom), 2'($urandom), $urandom, $urandom, gp, gn, rn, an);
      chk("tie_alternate", 32'(gp), 32'((i % 2) == 0));
    end
    if (if_req) begin
      issue(1'b0, 1'b0, 32'd0, 1'b0, 2'b00, 32'd0, 32'd0, gp, gn, rn, an);
    end

    // random traffic
    for (int t = 0; t < 150; t++) begin
      if (!if_req && !ls_req) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      a_if = 1'($urandom);
      a_ls = 1'($urandom);
      if (!a_if && !a_ls && !if_req && !ls_req) a_if = 1'b1;
      issue(a_if, a_ls, $urandom, 1'($urandom), 2'($urandom), $urandom, $urandom, gp, gn, rn, an);
    end
    while (if_req || ls_req) begin
      issue(1'b0, 1'b0, 32'd0, 1'b0, 2'b00, 32'd0, 32'd0, gp, gn, rn, an);
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // FAIR=0 instance with both ports requesting continuously
    c_if = 0; c_ls = 0;
    @(posedge clk); #1;
    p0_rst = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (p0_if_gnt) c_if++;
      if (p0_ls_gnt) c_ls++;
    end
    chk("fair0_if_starved", 32'(c_if), 32'd0);
    chk("fair0_ls_grants", 32'(c_ls), 32'd10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
